// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg                                                          |
// | Shared types and constants for the multi-cycle CPU front end.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_ISSUE  = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_perf_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_perf_counter                                               |
// | Retired-instruction and memory-wait-cycle counters (wrapping).   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_perf_counter
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               retire,
  input  logic               wait_cycle,
  output logic [INSTR_W-1:0] instr_count,
  output logic [INSTR_W-1:0] fetch_wait_count
);

  logic [INSTR_W-1:0] r_instr_count;
  logic [INSTR_W-1:0] r_wait_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= '0;
      r_wait_count  <= '0;
    end else begin
      if (retire)
        r_instr_count <= r_instr_count + 1'b1;
      if (wait_cycle)
        r_wait_count <= r_wait_count + 1'b1;
    end
  end

  assign instr_count      = r_instr_count;
  assign fetch_wait_count = r_wait_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit                                                       |
// | PC holder and req/ack instruction fetch FSM with halt handling.  |
// | Optional counters when FETCH_PERF_EN is defined.                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               halt,
  input  logic               goto,
  input  logic [31:0]        new_addr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IR,
  output logic [31:0]        PC,
  output logic [31:0]        PC_plus_1,
  output logic               ir_valid,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        instr_count,
  output logic [31:0]        fetch_wait_count
`endif
);

  fetch_state_t       r_state;
  logic [31:0]        r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [31:0]        w_pc_next_seq;
  logic [31:0]        w_redirect;

  assign w_pc_next_seq = r_pc + PC_INC;
  // Masking keeps the PC word aligned whatever the redirect target.
  assign w_redirect    = new_addr & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FS_BOOT;
      r_pc    <= RESET_PC & 32'hFFFF_FFFC;
      r_ir    <= '0;
    end else begin
      case (r_state)
        FS_BOOT:  r_state <= FS_FETCH;
        FS_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= FS_ISSUE;
          end
        end
        FS_ISSUE: begin
          if (!stall) begin
            if (halt) begin
              r_state <= FS_HALTED;
            end else if (goto) begin
              r_pc    <= w_redirect;
              r_state <= FS_FETCH;
            end else begin
              r_pc    <= w_pc_next_seq;
              r_state <= FS_FETCH;
            end
          end
        end
        FS_HALTED: r_state <= FS_HALTED;
        default:   r_state <= FS_BOOT;
      endcase
    end
  end

  assign imem_req  = (r_state == FS_FETCH);
  assign ir_valid  = (r_state == FS_ISSUE);
  assign halted    = (r_state == FS_HALTED);
  assign imem_addr = r_pc;
  assign PC        = r_pc;
  assign PC_plus_1 = w_pc_next_seq;
  assign IR        = r_ir;

`ifdef FETCH_PERF_EN
  logic w_retire;
  logic w_wait_cycle;

  assign w_retire     = (r_state == FS_ISSUE) && !stall;
  assign w_wait_cycle = (r_state == FS_FETCH) && !imem_ack;

  fetch_perf_counter u_perf (
    .clk              (clk),
    .rst              (rst),
    .retire           (w_retire),
    .wait_cycle       (w_wait_cycle),
    .instr_count      (instr_count),
    .fetch_wait_count (fetch_wait_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit                                                    |
// | Directed self-checking bench for fetch_unit (incl. PC wrap DUT). |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, halt, goto, imem_ack;
  logic [31:0] new_addr, imem_rdata;
  logic        imem_req, ir_valid, halted;
  logic [31:0] imem_addr, IR, PC, PC_plus_1;

  logic        rst_w, ack_w;
  logic [31:0] rdata_w;
  logic        req_w, irv_w, halted_w;
  logic [31:0] addr_w, ir_w, pc_w, pcp1_w;

`ifdef FETCH_PERF_EN
  logic [31:0] instr_count, fetch_wait_count;
  logic [31:0] instr_count_w, fetch_wait_count_w;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .goto(goto),
    .new_addr(new_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .PC(PC),
    .PC_plus_1(PC_plus_1), .ir_valid(ir_valid), .halted(halted)
`ifdef FETCH_PERF_EN
    , .instr_count(instr_count), .fetch_wait_count(fetch_wait_count)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(1'b0), .halt(1'b0), .goto(1'b0),
    .new_addr(32'h0), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .IR(ir_w), .PC(pc_w),
    .PC_plus_1(pcp1_w), .ir_valid(irv_w), .halted(halted_w)
`ifdef FETCH_PERF_EN
    , .instr_count(instr_count_w), .fetch_wait_count(fetch_wait_count_w)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait ack of the pending request; leaves the DUT in ISSUE.
  task automatic ack_now(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  logic [31:0] words [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    words[0] = 32'h2008_0001;
    words[1] = 32'h2009_0002;
    words[2] = 32'h200A_0003;
    rst = 1'b1; rst_w = 1'b1;
    stall = 1'b0; halt = 1'b0; goto = 1'b0; new_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0; ack_w = 1'b0; rdata_w = '0;
    repeat (2) tick();

    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_ir", IR, 32'h0);
    check_eq("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_halted", {31'b0, halted}, 32'h0);
    check_eq("rst_pc_plus_1", PC_plus_1, 32'h4);

    rst = 1'b0;
    check_eq("boot_no_req", {31'b0, imem_req}, 32'h0);
    tick();

    // Zero-wait sequential fetch: request every second cycle
    for (int i = 0; i < 3; i++) begin
      check_eq("seq_req", {31'b0, imem_req}, 32'h1);
      check_eq("seq_addr", imem_addr, 32'(i * 4));
      ack_now(words[i]);
      check_eq("seq_ir_valid", {31'b0, ir_valid}, 32'h1);
      check_eq("seq_ir", IR, words[i]);
      check_eq("seq_pc", PC, 32'(i * 4));
      check_eq("seq_req_low", {31'b0, imem_req}, 32'h0);
      tick();
    end

    // Three wait cycles, then a two-cycle stall at PC=0xC
    for (int i = 0; i < 3; i++) begin
      check_eq("wait_req", {31'b0, imem_req}, 32'h1);
      check_eq("wait_addr", imem_addr, 32'hC);
      tick();
    end
    ack_now(32'hAAAA_0004);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("stall_ir", IR, 32'hAAAA_0004);
      check_eq("stall_pc", PC, 32'hC);
      check_eq("stall_ir_valid", {31'b0, ir_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    check_eq("post_stall_addr", imem_addr, 32'h10);
    check_eq("post_stall_req", {31'b0, imem_req}, 32'h1);

    // Redirect from PC=0x10 to 0x40
    ack_now(32'h0800_0010);
    goto = 1'b1; new_addr = 32'h0000_0040;
    tick();
    goto = 1'b0;
    check_eq("goto_addr", imem_addr, 32'h40);
    check_eq("goto_req", {31'b0, imem_req}, 32'h1);

    // Misaligned redirect target is truncated
    ack_now(32'h0800_0040);
    goto = 1'b1; new_addr = 32'h0000_0043;
    tick();
    goto = 1'b0;
    check_eq("goto_misaligned_addr", imem_addr, 32'h40);
    check_eq("goto_misaligned_pc", PC, 32'h40);

    // goto while ir_valid=0 must be ignored
    goto = 1'b1; new_addr = 32'h0000_0080;
    tick();
    goto = 1'b0;
    check_eq("goto_ignored_addr", imem_addr, 32'h40);
    ack_now(32'h0000_0000);
    tick();
    check_eq("seq_after_goto_addr", imem_addr, 32'h44);

    // Move to 0x20 then halt with goto also asserted
    ack_now(32'h0800_0020);
    goto = 1'b1; new_addr = 32'h0000_0020;
    tick();
    goto = 1'b0;
    check_eq("to_halt_addr", imem_addr, 32'h20);
    ack_now(32'h0000_000C);
    halt = 1'b1; goto = 1'b1; new_addr = 32'h0000_0100;
    tick();
    check_eq("halted", {31'b0, halted}, 32'h1);
    check_eq("halt_pc", PC, 32'h20);
    check_eq("halt_ir_valid", {31'b0, ir_valid}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      tick();
      check_eq("halt_no_req", {31'b0, imem_req}, 32'h0);
    end
    imem_ack = 1'b0; halt = 1'b0; goto = 1'b0;
    check_eq("halt_pc_final", PC, 32'h20);
`ifdef FETCH_PERF_EN
    check_eq("perf_instr", instr_count, 32'd9);
    check_eq("perf_wait", fetch_wait_count, 32'd4);
`endif

    // Reset mid-fetch; stale ack in BOOT must be dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("refetch_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("abandon_req", {31'b0, imem_req}, 32'h0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_eq("stale_ir", IR, 32'h0);
    check_eq("stale_ir_valid", {31'b0, ir_valid}, 32'h0);
    check_eq("stale_req", {31'b0, imem_req}, 32'h1);
    check_eq("stale_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check_eq("perf_instr_rst", instr_count, 32'd0);
    check_eq("perf_wait_rst", fetch_wait_count, 32'd0);
`endif

    // PC wrap on the second instance
    rst_w = 1'b0;
    tick();
    tick();
    check_eq("wrap_addr", addr_w, 32'hFFFF_FFFC);
    check_eq("wrap_pc_plus_1", pcp1_w, 32'h0);
    ack_w = 1'b1; rdata_w = 32'h1234_5678;
    tick();
    ack_w = 1'b0;
    check_eq("wrap_ir", ir_w, 32'h1234_5678);
    tick();
    check_eq("wrap_pc", pc_w, 32'h0);
    check_eq("wrap_req", {31'b0, req_w}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
